// File: rtl/serial_tx.sv
// serial_tx: 8N1 serial transmitter fed through a byte buffer.
// Define SERIAL_TX_FIFO_EN for a 2**FIFO_AW-deep FIFO; otherwise a single holding register.
module serial_tx #(
   parameter int unsigned RCONST  = 868,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_START = 2'd1;
   localparam logic [1:0]  S_DATA  = 2'd2;
   localparam logic [1:0]  S_STOP  = 2'd3;
   localparam logic [15:0] T_LAST  = 16'(RCONST - 1);

   if (RCONST < 2 || RCONST > 65535 || FIFO_AW < 1) begin : g_bad_param
      $error("serial_tx: illegal parameter value");
   end

   logic [1:0]  state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        tx_q, tx_d;
   logic        push, pop;
   logic        buf_empty, buf_full;
   logic [7:0]  buf_head;

   assign push     = tx_valid & tx_ready;
   assign tx_ready = ~buf_full;
   assign tx       = tx_q;
   assign tx_busy  = (state_q != S_IDLE) | ~buf_empty;

`ifdef SERIAL_TX_FIFO_EN
   localparam int unsigned       DEPTH   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  PTR_ONE = (FIFO_AW + 1)'(1);

   logic [7:0]       mem_q [DEPTH];
   logic [FIFO_AW:0] wptr_q, rptr_q;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign buf_empty = (wptr_q == rptr_q);
   assign buf_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
   assign buf_head  = mem_q[rptr_q[FIFO_AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_ONE;
         if (pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= tx_byte;
   end
`else
   logic [7:0] hold_q;
   logic       hold_vld_q;

   assign buf_empty = ~hold_vld_q;
   assign buf_full  = hold_vld_q;
   assign buf_head  = hold_q;

   // Push needs an empty register and pop a full one, so they never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else if (push) begin
         hold_q     <= tx_byte;
         hold_vld_q <= 1'b1;
      end else if (pop) begin
         hold_vld_q <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

   // Next state; the line level is derived from the next state so tx is a clean flop.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      pop     = 1'b0;
      tx_d    = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (!buf_empty) begin
               pop     = 1'b1;
               shreg_d = buf_head;
               timer_d = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (timer_q == T_LAST) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = S_DATA;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_DATA: begin
            if (timer_q == T_LAST) begin
               timer_d = '0;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_STOP: begin
            if (timer_q == T_LAST) begin
               timer_d = '0;
               if (!buf_empty) begin
                  pop     = 1'b1;
                  shreg_d = buf_head;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shreg_d[idx_d];
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx; a line decoder pops expected bytes per frame.
module tb_serial_tx;

   localparam int RC    = 4;
   localparam int RC_B  = 868;
   localparam int FAW   = 2;
`ifdef SERIAL_TX_FIFO_EN
   localparam int DEPTH = 1 << FAW;
`else
   localparam int DEPTH = 1;
`endif
   localparam int FRAME = 10 * RC;
   localparam int BOUND = 2000;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] byte_a, byte_b;
   logic       valid_a, valid_b;
   logic       ready_a, ready_b;
   logic       tx_a, tx_b;
   logic       busy_a, busy_b;

   always #5 clk = ~clk;

   serial_tx #(.RCONST(RC), .FIFO_AW(FAW)) u_dut_a (
      .clk(clk), .reset(reset), .tx_byte(byte_a), .tx_valid(valid_a),
      .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a));

   serial_tx #(.RCONST(RC_B), .FIFO_AW(FAW)) u_dut_b (
      .clk(clk), .reset(reset), .tx_byte(byte_b), .tx_valid(valid_b),
      .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b));

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         starts_q[$];
   int         accepted = 0;
   int         started = 0;
   bit         mon_en = 1'b0;
   int         ns = 0;
   logic       samp [FRAME];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Judge a captured frame: every bit flat for RC cycles, start 0, stop 1, data vs scoreboard.
   task automatic eval_frame();
      logic [7:0] d;
      logic [7:0] e;
      bit steady;
      steady = 1'b1;
      for (int b = 0; b < 10; b++)
         for (int k = 1; k < RC; k++)
            if (samp[b*RC+k] !== samp[b*RC]) steady = 1'b0;
      check("bit_timing", 32'(steady), 32'd1);
      check("stop_bit", 32'(samp[9*RC]), 32'd1);
      for (int i = 0; i < 8; i++) d[i] = samp[(i+1)*RC];
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_frame: actual 0x%0h required none", d);
      end else begin
         e = exp_q.pop_front();
         check("frame_data", 32'(d), 32'(e));
      end
   endtask

   // Monitor: samples the line once per cycle and checks tx_ready against occupancy.
   initial begin
      forever begin
         @(negedge clk);
         if (reset || !mon_en) begin
            ns = 0;
         end else begin
            if (ns == 0) begin
               if (tx_a === 1'b0) begin
                  samp[0] = 1'b0;
                  ns = 1;
                  started++;
                  starts_q.push_back(cyc);
               end
            end else begin
               samp[ns] = tx_a;
               ns++;
               if (ns == FRAME) begin
                  eval_frame();
                  ns = 0;
               end
            end
            check("tx_ready", 32'(ready_a), 32'((accepted - started) < DEPTH));
         end
      end
   end

   // Called at a negedge; returns at a negedge after the handshake edge.
   task automatic push_a(input logic [7:0] b, output int hs_cyc);
      bit hs;
      int n;
      n = 0;
      hs_cyc = -1;
      valid_a = 1'b1;
      byte_a = b;
      while (hs_cyc < 0 && n < BOUND) begin
         #1 hs = ready_a;
         @(posedge clk);
         if (hs) begin
            exp_q.push_back(b);
            accepted++;
            #1 hs_cyc = cyc;
         end
         n++;
         @(negedge clk);
      end
      if (hs_cyc < 0) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: byte 0x%0h never accepted", b);
      end
   endtask

   task automatic idle_a();
      valid_a = 1'b0;
   endtask

   task automatic wait_idle(output int t);
      int n;
      n = 0;
      while ((busy_a || ns != 0) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: busy_a still %0b", busy_a);
      end
      t = cyc;
   endtask

   logic [7:0] burst [8];
   logic [7:0] d;
   int         h, t, rel, n;

   initial begin
      reset = 1'b1;
      valid_a = 1'b0; byte_a = '0;
      valid_b = 1'b0; byte_b = '0;
      burst = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'h81};

      // Reset state, with tx_valid asserted and ignored
      repeat (3) @(negedge clk);
      valid_a = 1'b1; byte_a = 8'h99;
      @(negedge clk);
      #1;
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_tx_b", 32'(tx_b), 32'd1);
      valid_a = 1'b0;

      // First frame: handshake on first edge after release, tx falls one edge later
      @(negedge clk);
      reset = 1'b0;
      mon_en = 1'b1;
      rel = cyc;
      starts_q.delete();
      push_a(8'hA5, h);
      idle_a();
      check("first_hs_edge", 32'(h), 32'(rel + 1));
      wait_idle(t);
      check("a5_frames", 32'(starts_q.size()), 32'd1);
      if (starts_q.size() > 0) check("a5_latency", 32'(starts_q[0]), 32'(h + 1));
      check("a5_busy_fall", 32'(t), 32'(h + FRAME + 1));

      // Burst pushed every cycle: buffer fills, frames stay contiguous
      starts_q.delete();
      foreach (burst[i]) push_a(burst[i], h);
      idle_a();
      wait_idle(t);
      check("burst_frames", 32'(starts_q.size()), 32'd8);
      for (int i = 1; i < starts_q.size(); i++)
         check("burst_gap", 32'(starts_q[i] - starts_q[i-1]), 32'(FRAME));
      check("burst_drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a frame
      mon_en = 1'b0;
      push_a(8'h00, h);
      idle_a();
      n = 0;
      while (cyc < h + 17 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check("midframe_low", 32'(tx_a), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("async_rst_tx", 32'(tx_a), 32'd1);
      check("async_rst_busy", 32'(busy_a), 32'd0);
      check("async_rst_ready", 32'(ready_a), 32'd1);
      exp_q.delete();
      accepted = 0;
      started = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      mon_en = 1'b1;
      starts_q.delete();
      push_a(8'h3C, h);
      idle_a();
      wait_idle(t);
      check("post_rst_frames", 32'(starts_q.size()), 32'd1);
      check("post_rst_drained", 32'(exp_q.size()), 32'd0);

      // Full-rate divider on the second instance
      valid_b = 1'b1; byte_b = 8'h41;
      #1 check("b_ready", 32'(ready_b), 32'd1);
      @(posedge clk);
      #1 h = cyc;
      @(negedge clk);
      valid_b = 1'b0;
      n = 0;
      while (tx_b !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("b_latency", 32'(cyc), 32'(h + 1));
      n = 0;
      while (tx_b === 1'b0 && n < 2 * RC_B) begin
         @(negedge clk);
         n++;
      end
      check("b_start_len", 32'(n), 32'(RC_B));
      repeat (RC_B / 2) @(negedge clk);
      d[0] = tx_b;
      for (int i = 1; i < 8; i++) begin
         repeat (RC_B) @(negedge clk);
         d[i] = tx_b;
      end
      check("b_data", 32'(d), 32'h41);
      repeat (RC_B) @(negedge clk);
      check("b_stop", 32'(tx_b), 32'd1);
      n = 0;
      while (busy_b && n < 2 * RC_B) begin
         @(negedge clk);
         n++;
      end
      check("b_frame_len", 32'(cyc), 32'(h + 10 * RC_B + 1));

      // Random push/stall traffic
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle_a();
            repeat ($urandom_range(1, 3 * FRAME / 10)) @(negedge clk);
         end
         push_a(8'($urandom), h);
      end
      idle_a();
      wait_idle(t);
      check("rand_lost", 32'(exp_q.size()), 32'd0);
      check("rand_count", 32'(started), 32'(accepted));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
